// File: rtl/decoder_scan_pkg.sv
// rtl/decoder_scan_pkg.sv - shared state encoding, channel constants and helpers for the decoder scan sequencer
package decoder_scan_pkg;

    localparam int CH_W = 2;
    localparam int N_CH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_BLANK = 2'd2
    } scan_state_t;

    // Index of the lowest set bit; callers guarantee the mask is non-zero.
    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
        lowest_set = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set = CH_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_rr_next_sel.sv
// rtl/decoder_scan_ctrl_rr_next_sel.sv - combinational round-robin pick of the next enabled channel after cur
module rr_next_sel
    import decoder_scan_pkg::*;
(
    input  logic [CH_W-1:0] cur,
    input  logic [N_CH-1:0] mask,
    output logic [CH_W-1:0] next,
    output logic            valid,
    output logic            wrapped
);

    logic [CH_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins;
    // offset N_CH lands back on cur, covering the single-channel mask.
    always_comb begin
        next  = cur;
        valid = 1'b0;
        idx   = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = cur + CH_W'(i);
            if (mask[idx]) begin
                next  = idx;
                valid = 1'b1;
            end
        end
        wrapped = valid && (next <= cur);
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - round-robin decoder scan sequencer; define SCAN_BLANK_EN for blanking between visits
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] mask,
    output logic       A0,
    output logic       A1,
    output logic       EN,
    output logic       busy,
    output logic       wrap
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    scan_state_t     state, state_nx;
    logic [7:0]      dwell_cnt, dwell_cnt_nx;
    logic [CH_W-1:0] ch, ch_nx;
    logic            stop_flag, stop_flag_nx;
    logic            stop_req;
    logic            wrap_nx;
    logic [CH_W-1:0] a_nx;
    logic            en_nx;
    logic            busy_nx;
    logic [CH_W-1:0] sel_next;
    logic            sel_valid;
    logic            sel_wrapped;

`ifdef SCAN_BLANK_EN
    localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);

    logic [7:0]      blank_cnt, blank_cnt_nx;
    logic [CH_W-1:0] pend_ch, pend_ch_nx;
    logic            pend_wrap, pend_wrap_nx;
`else
    logic unused_blank;
    assign unused_blank = (BLANK == 0);
`endif

    rr_next_sel u_rr_next_sel (
        .cur     (ch),
        .mask    (mask),
        .next    (sel_next),
        .valid   (sel_valid),
        .wrapped (sel_wrapped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dwell_cnt <= '0;
            ch        <= '0;
            stop_flag <= 1'b0;
            A1        <= 1'b0;
            A0        <= 1'b0;
            EN        <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_cnt <= '0;
            pend_ch   <= '0;
            pend_wrap <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            dwell_cnt <= dwell_cnt_nx;
            ch        <= ch_nx;
            stop_flag <= stop_flag_nx;
            A1        <= a_nx[1];
            A0        <= a_nx[0];
            EN        <= en_nx;
            busy      <= busy_nx;
            wrap      <= wrap_nx;
`ifdef SCAN_BLANK_EN
            blank_cnt <= blank_cnt_nx;
            pend_ch   <= pend_ch_nx;
            pend_wrap <= pend_wrap_nx;
`endif
        end
    end

    // A stop arriving on the deciding cycle itself still counts.
    assign stop_req = stop_flag | stop;

    always_comb begin
        state_nx     = state;
        dwell_cnt_nx = dwell_cnt;
        ch_nx        = ch;
        stop_flag_nx = stop_flag;
        wrap_nx      = 1'b0;
`ifdef SCAN_BLANK_EN
        blank_cnt_nx = blank_cnt;
        pend_ch_nx   = pend_ch;
        pend_wrap_nx = pend_wrap;
`endif
        case (state)
            S_IDLE: begin
                if (start && (mask != 4'b0000)) begin
                    state_nx     = S_DWELL;
                    ch_nx        = lowest_set(mask);
                    dwell_cnt_nx = '0;
                    stop_flag_nx = 1'b0;
                end
            end
            S_DWELL: begin
                stop_flag_nx = stop_req;
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt_nx = '0;
                    if (stop_req || !sel_valid) begin
                        state_nx     = S_IDLE;
                        stop_flag_nx = 1'b0;
                    end else begin
`ifdef SCAN_BLANK_EN
                        state_nx     = S_BLANK;
                        blank_cnt_nx = '0;
                        pend_ch_nx   = sel_next;
                        pend_wrap_nx = sel_wrapped;
`else
                        ch_nx        = sel_next;
                        wrap_nx      = sel_wrapped;
`endif
                    end
                end else begin
                    dwell_cnt_nx = dwell_cnt + 8'd1;
                end
            end
`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                stop_flag_nx = stop_req;
                if (blank_cnt == BLANK_LAST) begin
                    blank_cnt_nx = '0;
                    if (stop_req) begin
                        state_nx     = S_IDLE;
                        stop_flag_nx = 1'b0;
                    end else begin
                        state_nx     = S_DWELL;
                        dwell_cnt_nx = '0;
                        ch_nx        = pend_ch;
                        wrap_nx      = pend_wrap;
                    end
                end else begin
                    blank_cnt_nx = blank_cnt + 8'd1;
                end
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        a_nx    = '0;
        en_nx   = 1'b0;
        busy_nx = 1'b0;
        if (state_nx != S_IDLE) begin
            a_nx    = ch_nx;
            busy_nx = 1'b1;
        end
        if (state_nx == S_DWELL) begin
            en_nx = 1'b1;
        end
    end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Round-robin scan sequencer that drives the select and enable inputs of the team's 2-to-4 decoder (`A1`, `A0`, `EN`). It steps through four channels under an enable mask, holding each selected channel for a programmable dwell time, with optional blanking between channels. It sits directly upstream of the decoder in display-multiplex and channel-strobe paths.

## Interface
Parameters:
- `DWELL`, default 4: cycles `EN` is held high per channel visit; legal range 1..255.
- `BLANK`, default 1: blanking cycles between visits; legal range 1..255; used only when `SCAN_BLANK_EN` is defined.

Ports (clock and reset first):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin scanning; sampled only in IDLE.
- `stop` input 1: request halt; sampled only while busy; takes effect at the end of the current dwell.
- `mask` input 4: channel enables; bit i = 1 means channel i is scanned.
- `A0` output 1: select bit 0 to the decoder; registered.
- `A1` output 1: select bit 1 to the decoder; registered.
- `EN` output 1: decoder enable; registered.
- `busy` output 1: high in any state other than IDLE.
- `wrap` output 1: one-cycle pulse on the first dwell cycle of a visit whose index is not greater than the previous visit's index.

## Operation
- States:
  - IDLE: `EN`=0, `{A1,A0}`=00, `busy`=0.
  - DWELL: `EN`=1, `{A1,A0}` = current channel.
  - BLANK: `EN`=0, `{A1,A0}` hold the last channel. Exists only with `SCAN_BLANK_EN`.
- IDLE -> DWELL when `start`=1 and `mask`≠0. The first channel is the lowest set bit of `mask`. If `mask`=0, `start` is ignored and the block stays in IDLE.
- Next-channel pick: search round-robin from current+1 (mod 4) for the first set `mask` bit.
  - If only the current channel is set, it is picked again.
  - `mask` is sampled on the cycle the dwell counter expires.
- End of DWELL (counter reaches `DWELL`-1):
  - `stop` latched, or `mask`=0 at the pick -> IDLE.
  - Else with `SCAN_BLANK_EN` -> BLANK.
  - Else -> DWELL on the next channel.
- End of BLANK (`BLANK` cycles) -> DWELL on the channel chosen at the end of the preceding dwell.
- `stop` is latched by a sticky flag while busy and cleared on entry to IDLE. A `stop` asserted during BLANK still allows that BLANK to complete, then goes to IDLE with no further dwell.
- `start` while busy is ignored. `start` and `stop` together in IDLE: start wins.
- `wrap` rules:
  - Asserted when the newly entered channel index ≤ the previous channel index. This includes the single-channel mask case (every revisit).
  - Never asserted on the first visit after `start`.

## Timing
- Reset: the cycle after `rst` is sampled high, state = IDLE and `A0`=`A1`=`EN`=`busy`=`wrap`=0, `stop` flag = 0, dwell and blank counters = 0. Reset mid-dwell or mid-blank behaves identically, with no completion of the visit.
- `start` sampled at edge t: `EN`=1 with the selected channel from cycle t+1. Latency is 1.
- `EN` is high for exactly `DWELL` consecutive cycles per visit.
- Without blanking: back-to-back visits keep `EN` continuously high, and `{A1,A0}` changes on the same edge the new dwell starts.
- With blanking: `EN` is low for exactly `BLANK` cycles between visits, and `{A1,A0}` changes on the edge that enters the new DWELL.
- Stop: `EN` falls on the edge after the final dwell cycle (or after BLANK completes). `busy` falls on the same edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SCAN_BLANK_EN` defined: the BLANK state and blank counter are compiled in, and `BLANK` cycles of `EN`=0 separate visits.
- `SCAN_BLANK_EN` undefined: there is no BLANK state or counter, visits are back-to-back, and `BLANK` is unused.

## Structure
- Package `decoder_scan_pkg`:
  - state encoding constants IDLE/DWELL/BLANK (2-bit);
  - channel width constant `CH_W`=2;
  - channel count `N_CH`=4.
- Sub-module `rr_next_sel` (combinational): inputs current channel (2) and `mask` (4); outputs next channel (2), `valid`, and `wrapped`.
- Top level holds the state register, dwell and blank counters, stop flag, and output registers.

## Test plan
- Reset, then `start` with `mask`=1111 and `DWELL`=4, no blanking -> `EN` is continuously high and `{A1,A0}` goes 00,01,10,11,00, each held 4 cycles. `wrap` pulses on the return to 00.
- `mask`=1010 with `SCAN_BLANK_EN` and `BLANK`=2 -> channel 01 for 4 cycles, `EN`=0 for 2 cycles, channel 11 for 4 cycles, `EN`=0 for 2 cycles, then 01 with `wrap`=1.
- `stop` pulsed in cycle 2 of a dwell on channel 10 -> `EN` stays high through cycle 4, then `EN`=0, `busy`=0, `{A1,A0}`=00.
- `start` with `mask`=0000 -> remains IDLE with `EN`=0. `mask`=0100 -> channel 10 is revisited every 4 cycles with `wrap` on each revisit.
- Mask changed from 1111 to 0001 during a dwell on channel 01 -> the next visit is 00 with `wrap`=1. Mask set to 0000 mid-dwell -> IDLE at the end of the dwell.
- `rst` asserted in the middle of a dwell on channel 11 -> the next cycle shows all outputs 0 and IDLE. A following `start` begins at the lowest set bit of `mask`.
